rgb_pio_sequencer: RTL and testbench

Sequences pixel transfers between the Nios soft processor's parallel I/O ports and the video pixel datapath. Nios software posts a command word and an RGB colour on its PIO outputs using a toggle handshake. The block then performs one of three operations:
- a single-pixel write into the downstream pixel stream;
- a single-pixel read from the upstream stream;
- a burst fill of N identical pixels.

Status and read-back data return on the Nios PIO inputs. The block sits between the processor subsystem and the frame/pixel pipeline, in the processor clock domain.

---
 rtl/rgb_pio_sequencer.sv | 152 +++++++++++++++
 tb/tb_rgb_pio_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pio_sequencer.sv
// rtl/rgb_pio_sequencer.sv - Nios PIO toggle-handshake pixel write/read/fill sequencer
// One request per ack toggle; stream handshakes with per-operation timeout abort.
module rgb_pio_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [17:0] pio_cmd,
  input  logic [7:0]  pio_red,
  input  logic [7:0]  pio_green,
  input  logic [7:0]  pio_blue,
  output logic [17:0] pio_status,
  output logic [7:0]  rd_red,
  output logic [7:0]  rd_green,
  output logic [7:0]  rd_blue,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  input  logic [23:0] src_data,
  input  logic        src_valid,
  output logic        src_ready
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WRITE = 2'b01,
    S_READ  = 2'b10,
    S_FILL  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic        req_seen_q, req_seen_d;
  logic        ack_q, ack_d;
  logic        error_q, error_d;
  logic        nop_pend_q, nop_pend_d;
  logic [23:0] color_q, color_d;
  logic [14:0] remaining_q, remaining_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [23:0] rd_q, rd_d;
  logic        hs;
  logic        busy;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      req_seen_q  <= 1'b0;
      ack_q       <= 1'b0;
      error_q     <= 1'b0;
      nop_pend_q  <= 1'b0;
      color_q     <= '0;
      remaining_q <= '0;
      tmo_q       <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      req_seen_q  <= req_seen_d;
      ack_q       <= ack_d;
      error_q     <= error_d;
      nop_pend_q  <= nop_pend_d;
      color_q     <= color_d;
      remaining_q <= remaining_d;
      tmo_q       <= tmo_d;
      rd_q        <= rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_seen_d  = req_seen_q;
    ack_d       = ack_q;
    error_d     = error_q;
    nop_pend_d  = 1'b0;
    color_d     = color_q;
    remaining_d = remaining_q;
    tmo_d       = tmo_q;
    rd_d        = rd_q;
    pix_valid   = 1'b0;
    src_ready   = 1'b0;
    hs          = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A NOP (or zero-length FILL) acks one edge after its accept.
        if (nop_pend_q) begin
          ack_d = ~ack_q;
        end else if (pio_cmd[17] != req_seen_q) begin
          req_seen_d  = pio_cmd[17];
          color_d     = {pio_red, pio_green, pio_blue};
          error_d     = 1'b0;
          tmo_d       = '0;
          remaining_d = '0;
          case (pio_cmd[16:15])
            OP_WRITE: state_d = S_WRITE;
            OP_READ:  state_d = S_READ;
            OP_FILL: begin
              if (pio_cmd[14:0] != 15'd0) begin
                state_d     = S_FILL;
                remaining_d = pio_cmd[14:0];
              end else begin
                nop_pend_d = 1'b1;
              end
            end
            OP_NOP:   nop_pend_d = 1'b1;
          endcase
        end
      end
      S_WRITE, S_FILL: begin
        pix_valid = 1'b1;
        hs        = pix_ready;
      end
      S_READ: begin
        src_ready = 1'b1;
        hs        = src_valid;
      end
    endcase

    if (state_q != S_IDLE) begin
      if (hs) begin
        tmo_d = '0;
        if (state_q == S_READ) rd_d = src_data;
        if (state_q == S_FILL) remaining_d = remaining_q - 15'd1;
        if (state_q != S_FILL || remaining_q == 15'd1) begin
          state_d = S_IDLE;
          ack_d   = ~ack_q;
        end
      end else if (tmo_q == TMO_LAST) begin
        // Abort keeps remaining so software can see how far a FILL got.
        state_d = S_IDLE;
        ack_d   = ~ack_q;
        error_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign pio_status = {ack_q, busy, error_q, remaining_q};
  assign pix_data   = pix_valid ? color_q : 24'd0;
  assign rd_red     = rd_q[23:16];
  assign rd_green   = rd_q[15:8];
  assign rd_blue    = rd_q[7:0];

endmodule

// File: tb/tb_rgb_pio_sequencer.sv
// tb/tb_rgb_pio_sequencer.sv - self-checking bench for rgb_pio_sequencer
module tb_rgb_pio_sequencer;

  localparam int TC = 16;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [17:0] pio_cmd = '0;
  logic [7:0]  pio_red = '0, pio_green = '0, pio_blue = '0;
  logic [17:0] pio_status;
  logic [7:0]  rd_red, rd_green, rd_blue;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [23:0] src_data = '0;
  logic        src_valid = 1'b0;
  logic        src_ready;

  rgb_pio_sequencer #(.TIMEOUT_CYCLES(TC)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .pio_cmd(pio_cmd),
    .pio_red(pio_red), .pio_green(pio_green), .pio_blue(pio_blue),
    .pio_status(pio_status), .rd_red(rd_red), .rd_green(rd_green), .rd_blue(rd_blue),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready)
  );

  always #5 clk_clk = ~clk_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: op 0 idle, 1 write, 2 read, 3 fill; m_wait counts stall cycles.
  int          m_op, m_rem, m_wait;
  bit          m_seen, m_ack, m_err, m_nop, m_hs;
  logic [23:0] m_col, m_rd;

  always @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      m_op = 0; m_rem = 0; m_wait = 0; m_seen = 0; m_ack = 0; m_err = 0; m_nop = 0;
      m_col = '0; m_rd = '0;
    end else if (m_op == 0) begin
      if (m_nop) begin
        m_ack = !m_ack;
        m_nop = 0;
      end else if (pio_cmd[17] != m_seen) begin
        m_seen = pio_cmd[17];
        m_err  = 0;
        m_col  = {pio_red, pio_green, pio_blue};
        m_wait = 0;
        m_rem  = 0;
        case (pio_cmd[16:15])
          2'b01: m_op = 1;
          2'b10: m_op = 2;
          2'b11: if (pio_cmd[14:0] != 0) begin m_op = 3; m_rem = int'(pio_cmd[14:0]); end
                 else m_nop = 1;
          default: m_nop = 1;
        endcase
      end
    end else begin
      m_hs = (m_op == 2) ? src_valid : pix_ready;
      if (m_hs) begin
        m_wait = 0;
        if (m_op == 2) m_rd = src_data;
        if (m_op == 3) m_rem--;
        if (m_op != 3 || m_rem == 0) begin m_op = 0; m_ack = !m_ack; end
      end else begin
        m_wait++;
        if (m_wait == TC) begin m_op = 0; m_err = 1; m_ack = !m_ack; end
      end
    end
  end

  logic [23:0] beats[$];

  always @(negedge clk_clk) begin
    chk("model_status", 32'(pio_status), 32'({m_ack, (m_op != 0), m_err, 15'(m_rem)}));
    chk("model_pix_valid", 32'(pix_valid), 32'(m_op == 1 || m_op == 3));
    chk("model_src_ready", 32'(src_ready), 32'(m_op == 2));
    chk("model_rd", 32'({rd_red, rd_green, rd_blue}), 32'(m_rd));
    if (m_op == 1 || m_op == 3) chk("model_pix_data", 32'(pix_data), 32'(m_col));
    if (pix_valid && pix_ready) beats.push_back(pix_data);
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic issue(input bit t, input logic [1:0] op, input logic [14:0] cnt);
    pio_cmd = {t, op, cnt};
  endtask

  task automatic colour(input logic [23:0] c);
    {pio_red, pio_green, pio_blue} = c;
  endtask

  bit          pat[6]     = '{1, 0, 1, 1, 0, 1};
  int          exp_rem[6] = '{4, 3, 3, 2, 1, 1};
  int          n;

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_status", 32'(pio_status), 32'h0);
    chk("rst_pix_valid", 32'(pix_valid), 32'h0);
    chk("rst_src_ready", 32'(src_ready), 32'h0);
    reset_reset_n = 1'b1;
    tick();

    // WRITE 0x123456 with ready high
    colour(24'h123456); pix_ready = 1'b1; beats.delete();
    issue(1, 2'b01, 0);
    tick();
    chk("wr_busy", 32'(pio_status[16]), 32'h1);
    chk("wr_pix_data", 32'(pix_data), 32'h123456);
    chk("wr_ack_before", 32'(pio_status[17]), 32'h0);
    tick();
    chk("wr_ack_after", 32'(pio_status[17]), 32'h1);
    chk("wr_busy_after", 32'(pio_status[16]), 32'h0);
    chk("wr_beats", 32'(beats.size()), 32'h1);
    if (beats.size() > 0) chk("wr_beat0", 32'(beats[0]), 32'h123456);

    // READ with 5 cycles of source backpressure
    pix_ready = 1'b0; src_data = 24'hA0B0C0; src_valid = 1'b0;
    issue(0, 2'b10, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("rd_src_ready_wait", 32'(src_ready), 32'h1);
      tick();
    end
    src_valid = 1'b1;
    chk("rd_src_ready_hs", 32'(src_ready), 32'h1);
    tick();
    src_valid = 1'b0; src_data = 24'h0;
    chk("rd_red", 32'(rd_red), 32'hA0);
    chk("rd_green", 32'(rd_green), 32'hB0);
    chk("rd_blue", 32'(rd_blue), 32'hC0);
    chk("rd_status", 32'(pio_status), 32'h0);

    // FILL 4 with ready pattern 1,0,1,1,0,1; colour inputs change mid-burst
    colour(24'hAABBCC); beats.delete();
    issue(1, 2'b11, 15'd4);
    tick();
    for (int i = 0; i < 6; i++) begin
      pix_ready = pat[i];
      if (i == 2) pio_red = 8'h11;
      chk("fill_remaining", 32'(pio_status[14:0]), 32'(exp_rem[i]));
      tick();
    end
    pix_ready = 1'b0;
    chk("fill_status_done", 32'(pio_status), 32'h20000);
    chk("fill_beats", 32'(beats.size()), 32'h4);
    foreach (beats[i]) chk("fill_beat_colour", 32'(beats[i]), 32'hAABBCC);

    // WRITE timeout with ready held low
    colour(24'h010203);
    issue(0, 2'b01, 0);
    tick();
    repeat (TC - 1) tick();
    chk("to_busy_before", 32'(pio_status[16]), 32'h1);
    chk("to_valid_before", 32'(pix_valid), 32'h1);
    tick();
    chk("to_status", 32'(pio_status), 32'h08000);
    chk("to_valid_after", 32'(pix_valid), 32'h0);

    // NOP clears error, acks one edge after accept
    issue(1, 2'b00, 0);
    tick();
    chk("nop_status_t", 32'(pio_status), 32'h00000);
    tick();
    chk("nop_status_t1", 32'(pio_status), 32'h20000);

    // FILL with count 0 acts as NOP
    issue(0, 2'b11, 0);
    tick();
    chk("fill0_status_t", 32'(pio_status), 32'h20000);
    tick();
    chk("fill0_status_t1", 32'(pio_status), 32'h00000);

    // Toggle flipped twice during FILL is ignored
    colour(24'h445566); pix_ready = 1'b0; beats.delete();
    issue(1, 2'b11, 15'd3);
    tick();
    chk("ign_busy", 32'(pio_status[16]), 32'h1);
    issue(0, 2'b01, 0);
    tick();
    issue(1, 2'b10, 0);
    tick();
    pix_ready = 1'b1;
    repeat (3) tick();
    repeat (4) tick();
    chk("ign_status", 32'(pio_status), 32'h20000);
    chk("ign_beats", 32'(beats.size()), 32'h3);

    // FILL 5 aborted after 2 beats keeps remaining=3
    colour(24'h778899); pix_ready = 1'b1;
    issue(0, 2'b11, 15'd5);
    tick();
    tick(); tick();
    pix_ready = 1'b0;
    n = 0;
    while (pio_status[16] && n < 40) begin
      tick();
      n++;
    end
    chk("abort_cycles", 32'(n), 32'(TC));
    chk("abort_status", 32'(pio_status), 32'h08003);

    // Asynchronous reset in the middle of a FILL
    colour(24'hCAFE01); pix_ready = 1'b1;
    issue(1, 2'b11, 15'd10);
    tick(); tick(); tick();
    reset_reset_n = 1'b0;
    #1;
    chk("arst_pix_valid", 32'(pix_valid), 32'h0);
    chk("arst_status", 32'(pio_status), 32'h0);
    chk("arst_rd", 32'({rd_red, rd_green, rd_blue}), 32'h0);
    pio_cmd = '0;
    tick(); tick();
    reset_reset_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(pio_status), 32'h0);
    colour(24'h0F0E0D);
    issue(1, 2'b01, 0);
    tick();
    chk("post_rst_busy", 32'(pio_status[16]), 32'h1);
    tick();
    chk("post_rst_ack", 32'(pio_status), 32'h20000);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
